// File: rtl/seg_display_mmio_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_mmio_if
// Description : Single-port register bus between the core and the display.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_display_mmio_if;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, output addr, output wdata, input rdata);
    modport slave  (input we, input addr, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/seg_display_mmio.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_mmio
// Description : Memory-mapped multiplexed seven-segment display controller
//               with leading-zero blanking, blinking and selectable polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_mmio #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    seg_display_mmio_if.slave      bus,
    output logic [7:0]             o_seg,
    output logic [DIGITS-1:0]      o_sel
);

    localparam int c_scan_w  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_frame_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [7:0]        c_seg_off = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] c_sel_off = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    localparam logic [2:0] c_addr_data_lo = 3'd0;
    localparam logic [2:0] c_addr_data_hi = 3'd1;
    localparam logic [2:0] c_addr_ctrl    = 3'd2;
    localparam logic [2:0] c_addr_dp      = 3'd3;
    localparam logic [2:0] c_addr_status  = 3'd4;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DIGITS*4-1:0] r_data;
    logic [2:0]          r_ctrl;
    logic [DIGITS-1:0]   r_dp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_ctrl <= 3'b001;
            r_dp   <= '0;
        end else if (bus.we) begin
            // Digits 0..7 live in DATA_LO, digits 8..15 in DATA_HI
            for (int i = 0; i < DIGITS; i++) begin
                if ((i < 8 && bus.addr == c_addr_data_lo) ||
                    (i >= 8 && bus.addr == c_addr_data_hi)) begin
                    r_data[4*i +: 4] <= bus.wdata[4*(i%8) +: 4];
                end
            end
            if (bus.addr == c_addr_ctrl) begin
                r_ctrl <= bus.wdata[2:0];
            end
            if (bus.addr == c_addr_dp) begin
                r_dp <= bus.wdata[DIGITS-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan, frame and blink counters (free-running, independent of CTRL)
    // ------------------------------------------------------------------
    logic [c_scan_w-1:0]  r_scan;
    logic [3:0]           r_idx;
    logic [c_frame_w-1:0] r_frame;
    logic                 r_blink;

    logic w_scan_last;
    logic w_idx_last;
    logic w_frame_last;

    assign w_scan_last  = (r_scan == c_scan_w'(SCAN_DIV - 1));
    assign w_idx_last   = (r_idx == 4'(DIGITS - 1));
    assign w_frame_last = (r_frame == c_frame_w'(BLINK_FRAMES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan  <= '0;
            r_idx   <= '0;
            r_frame <= '0;
            r_blink <= 1'b1;
        end else if (w_scan_last) begin
            r_scan <= '0;
            if (w_idx_last) begin
                r_idx <= '0;
                if (w_frame_last) begin
                    r_frame <= '0;
                    r_blink <= ~r_blink;
                end else begin
                    r_frame <= r_frame + c_frame_w'(1);
                end
            end else begin
                r_idx <= r_idx + 4'd1;
            end
        end else begin
            r_scan <= r_scan + c_scan_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Current-digit selection and decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    logic [DIGITS-1:0] w_upper_zero;
    logic [DIGITS-1:0] w_sel_hi;
    logic [3:0]        w_nib;
    logic              w_dp;
    logic              w_lz;
    logic              w_blink_off;
    logic [7:0]        w_seg_hi;

    always_comb begin
        logic run;
        run          = 1'b1;
        w_upper_zero = '0;
        // Bit k set when nibbles k..DIGITS-1 are all zero
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run             = run & (r_data[4*k +: 4] == 4'h0);
            w_upper_zero[k] = run;
        end
    end

    always_comb begin
        w_nib    = '0;
        w_dp     = 1'b0;
        w_lz     = 1'b0;
        w_sel_hi = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == 4'(k)) begin
                w_nib       = r_data[4*k +: 4];
                w_dp        = r_dp[k];
                w_lz        = (k > 0) && w_upper_zero[k];
                w_sel_hi[k] = 1'b1;
            end
        end
    end

    assign w_blink_off = r_ctrl[2] & ~r_blink;

    always_comb begin
        w_seg_hi = '0;
        if (!((r_ctrl[1] && w_lz) || w_blink_off)) begin
            w_seg_hi[6:0] = hex7(w_nib);
        end
        w_seg_hi[7] = w_dp & ~w_blink_off;
    end

    // ------------------------------------------------------------------
    // Registered pin drivers; async reset forces inactive levels at once
    // ------------------------------------------------------------------
    logic [7:0]        r_seg;
    logic [DIGITS-1:0] r_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= c_seg_off;
            r_sel <= c_sel_off;
        end else if (r_ctrl[0]) begin
            r_seg <= w_seg_hi ^ c_seg_off;
            r_sel <= w_sel_hi ^ c_sel_off;
        end else begin
            r_seg <= c_seg_off;
            r_sel <= c_sel_off;
        end
    end

    assign o_seg = r_seg;
    assign o_sel = r_sel;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_data_lo;
    logic [31:0] w_data_hi;
    logic [31:0] w_rdata;

    always_comb begin
        w_data_lo = '0;
        w_data_hi = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i < 8) begin
                w_data_lo[4*(i%8) +: 4] = r_data[4*i +: 4];
            end else begin
                w_data_hi[4*(i%8) +: 4] = r_data[4*i +: 4];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.addr)
            c_addr_data_lo: w_rdata = w_data_lo;
            c_addr_data_hi: w_rdata = w_data_hi;
            c_addr_ctrl:    w_rdata = {29'd0, r_ctrl};
            c_addr_dp:      w_rdata = 32'(r_dp);
            c_addr_status:  w_rdata = {27'd0, r_blink, r_idx};
            default:        w_rdata = '0;
        endcase
    end

    assign bus.rdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_mmio
// Description : Self-checking bench for seg_display_mmio (4 digits, fast scan).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_mmio;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int ACTIVE_LOW   = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] o_seg;
    logic [3:0] o_sel;

    seg_display_mmio_if bus ();

    seg_display_mmio #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES),
        .ACTIVE_LOW   (ACTIVE_LOW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .o_seg (o_seg),
        .o_sel (o_sel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: edges since reset release plus shadow registers
    longint      t;
    logic [15:0] m_data;
    logic [2:0]  m_ctrl;
    logic [3:0]  m_dp;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_sel;

    logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    function automatic int idx_at(longint tt);
        return int'((tt / SCAN_DIV) % DIGITS);
    endfunction

    function automatic bit phase_at(longint tt);
        longint frame = tt / (SCAN_DIV * DIGITS);
        return ((frame / BLINK_FRAMES) % 2) == 0;
    endfunction

    function automatic logic [11:0] model_out(longint tt, logic [15:0] d, logic [2:0] c, logic [3:0] p);
        int         k;
        bit         blink_off;
        bit         lz;
        logic [3:0] nib;
        logic [15:0] upper;
        logic [7:0] seg;
        logic [3:0] sel;
        seg = 8'h00;
        sel = 4'h0;
        if (c[0]) begin
            k         = idx_at(tt);
            upper     = d >> (4 * k);
            nib       = upper[3:0];
            blink_off = c[2] && !phase_at(tt);
            lz        = c[1] && (k > 0) && (upper == 16'h0);
            seg[6:0]  = (lz || blink_off) ? 7'h00 : hex_tab[nib][6:0];
            seg[7]    = p[k] && !blink_off;
            sel       = 4'(1 << k);
        end
        return {~sel, ~seg};
    endfunction

    function automatic logic [31:0] rd_model(logic [2:0] a);
        case (a)
            3'd0:    return {16'h0, m_data};
            3'd2:    return {29'h0, m_ctrl};
            3'd3:    return {28'h0, m_dp};
            3'd4:    return {27'h0, phase_at(t), 4'(idx_at(t))};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_data = '0;
        m_ctrl = 3'b001;
        m_dp   = '0;
        t      = 0;
    endtask

    task automatic tick();
        logic [15:0] sd;
        logic [2:0]  sc;
        logic [3:0]  sp;
        sd = m_data;
        sc = m_ctrl;
        sp = m_dp;
        if (bus.we) begin
            case (bus.addr)
                3'd0:    m_data = bus.wdata[15:0];
                3'd2:    m_ctrl = bus.wdata[2:0];
                3'd3:    m_dp   = bus.wdata[3:0];
                default: ;
            endcase
        end
        @(posedge clk);
        {exp_sel, exp_seg} = model_out(t, sd, sc, sp);
        t++;
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (o_seg !== 8'hFF || o_sel !== 4'hF) begin
            $display("FAIL reset_outputs: seg=%h sel=%b, want seg=ff sel=1111", o_seg, o_sel);
        end else n_pass++;
        bus.addr = 3'd2;
        #1;
        n_checks++;
        if (bus.rdata !== 32'h1) $display("FAIL reset_ctrl: got %h want 00000001", bus.rdata);
        else n_pass++;
        bus.addr = 3'd4;
        #1;
        n_checks++;
        if (bus.rdata !== 32'h10) $display("FAIL reset_status: got %h want 00000010", bus.rdata);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        tick();
        n_checks++;
        if (o_sel !== 4'b1110 || o_seg !== exp_seg) begin
            $display("FAIL reset_first_digit: seg=%h sel=%b, want seg=%h sel=1110", o_seg, o_sel, exp_seg);
        end else n_pass++;
    endtask

    task automatic test_digit_scan();
        logic [7:0] tp [4] = '{8'hB0, 8'h0E, 8'h92, 8'h88};
        wr(3'd0, 32'h0000_A5F3);
        wr(3'd3, 32'h0000_0002);
        repeat (40) begin
            tick();
            n_checks++;
            if (o_seg !== exp_seg || o_sel !== exp_sel) begin
                $display("FAIL scan: seg=%h sel=%b, want seg=%h sel=%b", o_seg, o_sel, exp_seg, exp_sel);
            end else n_pass++;
            for (int k = 0; k < 4; k++) begin
                if (o_sel === ~(4'b0001 << k)) begin
                    n_checks++;
                    if (o_seg !== tp[k]) $display("FAIL scan_digit%0d: seg=%h want %h", k, o_seg, tp[k]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        wr(3'd2, 32'h3);
        wr(3'd0, 32'h0000_0007);
        repeat (24) begin
            tick();
            n_checks++;
            if (o_seg !== exp_seg || o_sel !== exp_sel) begin
                $display("FAIL lzb_seven: seg=%h sel=%b, want seg=%h sel=%b", o_seg, o_sel, exp_seg, exp_sel);
            end else n_pass++;
        end
        wr(3'd0, 32'h0);
        repeat (24) begin
            tick();
            n_checks++;
            if (o_seg !== exp_seg || o_sel !== exp_sel) begin
                $display("FAIL lzb_zero: seg=%h sel=%b, want seg=%h sel=%b", o_seg, o_sel, exp_seg, exp_sel);
            end else n_pass++;
        end
    endtask

    task automatic test_blink();
        logic [31:0] exp_rd;
        wr(3'd2, 32'h5);
        wr(3'd0, {16'h0, 16'($urandom)});
        bus.addr = 3'd4;
        repeat (150) begin
            tick();
            exp_rd = rd_model(3'd4);
            n_checks++;
            if (o_seg !== exp_seg || o_sel !== exp_sel || bus.rdata !== exp_rd) begin
                $display("FAIL blink: seg=%h sel=%b st=%h, want seg=%h sel=%b st=%h",
                         o_seg, o_sel, bus.rdata, exp_seg, exp_sel, exp_rd);
            end else n_pass++;
        end
    endtask

    task automatic test_disable();
        logic [31:0] exp_rd;
        wr(3'd2, 32'h0);
        bus.addr = 3'd4;
        repeat (20) begin
            tick();
            exp_rd = rd_model(3'd4);
            n_checks++;
            if (o_seg !== 8'hFF || o_sel !== 4'hF || bus.rdata !== exp_rd) begin
                $display("FAIL disable: seg=%h sel=%b st=%h, want seg=ff sel=1111 st=%h",
                         o_seg, o_sel, bus.rdata, exp_rd);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        wr(3'd2, 32'h1);
        wr(3'd0, 32'h0000_1234);
        guard = 0;
        while (!(idx_at(t) == 2 && (t % SCAN_DIV) == 1) && guard < 100) begin
            tick();
            guard++;
        end
        n_checks++;
        if (o_sel !== 4'b1011) $display("FAIL reset_mid_pre: sel=%b want 1011", o_sel);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (o_seg !== 8'hFF || o_sel !== 4'hF) begin
            $display("FAIL reset_mid_async: seg=%h sel=%b, want seg=ff sel=1111", o_seg, o_sel);
        end else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        tick();
        n_checks++;
        if (o_sel !== 4'b1110 || o_seg !== exp_seg) begin
            $display("FAIL reset_mid_first: seg=%h sel=%b, want seg=%h sel=1110", o_seg, o_sel, exp_seg);
        end else n_pass++;
        bus.addr = 3'd0;
        #1;
        n_checks++;
        if (bus.rdata !== 32'h0) $display("FAIL reset_mid_data: got %h want 00000000", bus.rdata);
        else n_pass++;
        bus.addr = 3'd2;
        #1;
        n_checks++;
        if (bus.rdata !== 32'h1) $display("FAIL reset_mid_ctrl: got %h want 00000001", bus.rdata);
        else n_pass++;
    endtask

    task automatic test_reg_access();
        logic [2:0]  addrs [5] = '{3'd1, 3'd6, 3'd3, 3'd0, 3'd2};
        logic [31:0] want  [5] = '{32'h0, 32'h0, 32'hF, 32'hFFFF, 32'h7};
        for (int i = 0; i < 5; i++) begin
            wr(addrs[i], 32'hFFFF_FFFF);
            bus.addr = addrs[i];
            #1;
            n_checks++;
            if (bus.rdata !== want[i]) $display("FAIL reg_rw addr%0d: got %h want %h", addrs[i], bus.rdata, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [2:0]  a;
        logic [31:0] exp_rd;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                wr(3'($urandom_range(0, 7)), $urandom);
            end else begin
                tick();
            end
            a        = 3'($urandom_range(0, 7));
            bus.addr = a;
            #1;
            exp_rd = rd_model(a);
            n_checks++;
            if (o_seg !== exp_seg || o_sel !== exp_sel || bus.rdata !== exp_rd) begin
                $display("FAIL random: seg=%h sel=%b rd[%0d]=%h, want seg=%h sel=%b rd=%h",
                         o_seg, o_sel, a, bus.rdata, exp_seg, exp_sel, exp_rd);
            end else n_pass++;
        end
    endtask

    initial begin
        bus.we    = 1'b0;
        bus.addr  = 3'd0;
        bus.wdata = 32'h0;
        model_reset();
        test_reset();
        test_digit_scan();
        test_leading_zero();
        test_blink();
        test_disable();
        test_reset_mid();
        test_reg_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_mmio.md
# seg_display_mmio

Memory-mapped, parametrised seven-segment display controller, the generalised successor of the fixed 8-digit scanner. The core writes hex digit data, decimal-point mask and mode bits through a single-port register interface. The block time-multiplexes DIGITS digits onto shared segment lines and adds leading-zero blanking, blinking and selectable output polarity. It sits beside DMEM on the core's data bus and drives the board's o_seg/o_sel pins directly.

## Interface
- DIGITS, 8, number of digits scanned; legal range 1..16.
- SCAN_DIV, 50000, clk cycles each digit is held; must be ≥ 2.
- BLINK_FRAMES, 64, full scan frames per blink half-period; must be ≥ 1.
- ACTIVE_LOW, 1, 1 = o_seg/o_sel driven active-low; 0 = active-high.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  register write strobe, sampled on rising clk.
- addr  in  3  register select.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from addr.
- o_seg  out  8  segments {dp,g,f,e,d,c,b,a}.
- o_sel  out  DIGITS  one-hot digit select.

## Operation
- Register map:
  - 0 DATA_LO: nibble i = digit i, for i = 0..7.
  - 1 DATA_HI: nibble i = digit 8+i.
  - 2 CTRL: [0] enable, [1] leading-zero blank, [2] blink enable.
  - 3 DP: bit i = decimal point of digit i.
  - 4 STATUS (read-only): [3:0] current digit index, [4] blink phase (1 = visible).
  - 5–7: read 0; writes ignored.
- Register widths and reset values:
  - Nibbles and DP bits at index ≥ DIGITS are not stored and read 0.
  - DATA_HI is wholly absent when DIGITS ≤ 8.
  - CTRL resets to 0x1; all other registers reset to 0.
  - Unused CTRL bits read 0.
- Scan state:
  - Scan counter runs 0..SCAN_DIV-1.
  - On its wrap, the digit index advances by 1 modulo DIGITS.
  - When the digit index wraps DIGITS-1→0, the frame counter advances 0..BLINK_FRAMES-1.
  - On the frame counter's wrap, blink phase toggles.
  - Counters run regardless of CTRL.
- Hex decode, active-high pattern {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Digit blanking (segments g..a forced off) applies when either:
  - leading-zero blank is set, digit index k>0, and nibbles k..DIGITS-1 are all zero; or
  - blink is enabled and blink phase = 0.
  - Digit 0 is never blanked by the leading-zero rule.
- dp = DP[k], unaffected by leading-zero blanking, forced off by blink-off.
- enable = 0: all segments and all selects inactive; counters keep running.
- Output polarity: ACTIVE_LOW=1 inverts both o_seg and o_sel.
- Inactive output levels (also the reset levels):
  - ACTIVE_LOW=1: o_seg=8'hFF, o_sel all ones.
  - ACTIVE_LOW=0: all zeros.

## Timing
- o_seg and o_sel are registered; they update one cycle after the digit index changes.
- Writes take effect at the rising edge where we=1. Register contents are visible on rdata in the following cycle, and on o_seg in the cycle after that.
- A write and a digit advance in the same cycle: the output register samples the pre-write register value; the new value appears one cycle later.
- Reset asserted mid-scan, at any time:
  - Outputs go to inactive levels immediately, without waiting for a clock edge.
  - Counters, digit index and blink phase go to 0/0/1.
  - After release, the first o_sel activation is digit 0, at the first rising edge.
- DIGITS=1: the digit index stays 0; every scan-counter wrap also counts a frame.
- Frame period = DIGITS·SCAN_DIV cycles. Blink period = 2·BLINK_FRAMES frames.

## Test plan
Parameters for all scenarios: DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1.
1. Reset, then write DATA_LO=0x0000_A5F3, DP=0x2 -> o_sel cycles through 1110, 1101, 1011, 0111, each held 4 cycles. Corresponding o_seg values: 0xB0, 0x0E (dp on), 0x92, 0x88.
2. CTRL=0x3, DATA_LO=0x0000_0007 -> digits 1–3 show o_seg=0xFF; digit 0 shows 0xF8. Then DATA_LO=0 -> digit 0 shows 0xC0.
3. CTRL=0x5 -> visible for 2 frames (32 cycles), then all o_seg=0xFF for 32 cycles, repeating. STATUS[4] tracks the visible/blank phase.
4. CTRL=0x0 mid-scan -> o_sel=1111 and o_seg=0xFF from the next cycle. STATUS[3:0] keeps advancing.
5. Assert reset mid-digit-2 -> outputs at inactive levels immediately. After release, first active select is 1110; rdata at addr 0 = 0 and at addr 2 = 0x1.
6. Write addr 1 (DATA_HI) and addr 6 with 0xFFFF_FFFF -> both read 0. Write DP=0xFF -> DP reads 0xF.
